multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide engine in the execute stage, alongside the ALU. It accepts a mul/div instruction issued from the D/X latch and runs it over multiple cycles. While it runs, it exports a busy flag and the latched instruction, which the hazard/stall logic uses to stall dependent or second mul/div instructions. It returns the result, destination register and exception flag to writeback through a valid/ready handshake.

---
 rtl/multdiv_unit_if.sv | 28 ++
 rtl/multdiv_unit.sv | 175 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Execute-stage mul/div bus: issue operands from D/X, results out to writeback.
interface multdiv_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic [31:0]       dx_insn;
  logic              dx_valid;
  logic [DATA_W-1:0] dx_opA;
  logic [DATA_W-1:0] dx_opB;
  logic              wb_ready;
  logic              mult_ongoing;
  logic [31:0]       md_insn;
  logic [DATA_W-1:0] md_result;
  logic [4:0]        md_rd;
  logic              md_exception;
  logic              md_result_valid;

  // Issue/writeback side
  modport master (
    output dx_insn, dx_valid, dx_opA, dx_opB, wb_ready,
    input  mult_ongoing, md_insn, md_result, md_rd, md_exception, md_result_valid
  );

  // Mul/div unit side
  modport slave (
    input  dx_insn, dx_valid, dx_opA, dx_opB, wb_ready,
    output mult_ongoing, md_insn, md_result, md_rd, md_exception, md_result_valid
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine.
module multdiv_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [4:0]  MUL_ALUOP = 5'b00110,
  parameter logic [4:0]  DIV_ALUOP = 5'b00111
) (
  input  logic           clock,
  input  logic           reset_n,
  multdiv_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t              state;
  logic [31:0]         md_insn_q;
  logic [DATA_W-1:0]   result_q;
  logic                exc_q;
  logic                valid_q;
  logic                busy_q;
  logic                is_div_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;   // multiplicand, or divisor magnitude
  logic [2*DATA_W+1:0] acc;     // {hi(W+1), multiplier(W), q-1}
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;

  logic              start;
  logic [4:0]        aluop;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;

  // Issue decode and operand magnitudes for division
  always_comb begin
    aluop = bus.dx_insn[6:2];
    start = bus.dx_valid && (bus.dx_insn[31:27] == 5'd0) &&
            ((aluop == MUL_ALUOP) || (aluop == DIV_ALUOP));
    mag_a = bus.dx_opA[DATA_W-1] ? -bus.dx_opA : bus.dx_opA;
    mag_b = bus.dx_opB[DATA_W-1] ? -bus.dx_opB : bus.dx_opB;
  end

  logic [DATA_W:0]     hi;
  logic [DATA_W:0]     hi_sum;
  logic [DATA_W:0]     mext;
  logic [2*DATA_W+1:0] acc_next;

  // One Booth step; the high part carries a guard bit so subtracting the
  // most negative multiplicand cannot overflow.
  always_comb begin
    hi   = acc[2*DATA_W+1:DATA_W+1];
    mext = {mcand[DATA_W-1], mcand};
    case (acc[1:0])
      2'b01:   hi_sum = hi + mext;
      2'b10:   hi_sum = hi - mext;
      default: hi_sum = hi;
    endcase
    acc_next = {hi_sum[DATA_W], hi_sum, acc[DATA_W:1]};
  end

  logic [DATA_W:0]   r_sh;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  // One restoring-division step on magnitudes
  always_comb begin
    r_sh = {rem, quo[DATA_W-1]};
    diff = r_sh - {1'b0, mcand};
    if (diff[DATA_W]) begin
      rem_next = rem;
      rem_next = r_sh[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end
  end

  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quotient;
  logic                mul_ovf;
  logic                div_ovf;

  // Final sign fix-up and overflow detection
  always_comb begin
    product  = acc[2*DATA_W:1];
    mul_ovf  = !((&product[2*DATA_W-1:DATA_W-1]) || !(|product[2*DATA_W-1:DATA_W-1]));
    quotient = neg_q ? -quo : quo;
    div_ovf  = !neg_q && quo[DATA_W-1];
  end

  // Control FSM with registered results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      md_insn_q <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            md_insn_q <= bus.dx_insn;
            result_q  <= '0;
            exc_q     <= 1'b0;
            busy_q    <= 1'b1;
            cnt       <= '0;
            if (aluop == DIV_ALUOP) begin
              is_div_q <= 1'b1;
              neg_q    <= bus.dx_opA[DATA_W-1] ^ bus.dx_opB[DATA_W-1];
              mcand    <= mag_b;
              quo      <= mag_a;
              rem      <= '0;
              if (bus.dx_opB == '0) begin
                exc_q   <= 1'b1;
                valid_q <= 1'b1;
                state   <= DONE;
              end else begin
                state   <= DIV;
              end
            end else begin
              is_div_q <= 1'b0;
              mcand    <= bus.dx_opA;
              acc      <= {{(DATA_W+1){1'b0}}, bus.dx_opB, 1'b0};
              state    <= MUL;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          result_q <= is_div_q ? quotient : product[DATA_W-1:0];
          exc_q    <= is_div_q ? div_ovf : mul_ovf;
          valid_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (bus.wb_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mult_ongoing    = busy_q;
  assign bus.md_insn         = md_insn_q;
  assign bus.md_result       = result_q;
  assign bus.md_rd           = md_insn_q[26:22];
  assign bus.md_exception    = exc_q;
  assign bus.md_result_valid = valid_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, signed results, exceptions,
// writeback back-pressure and asynchronous abort.
module tb_multdiv_unit;
  logic clock;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  multdiv_unit_if #(.DATA_W(32)) bus ();

  multdiv_unit #(
    .DATA_W(32),
    .MUL_ALUOP(5'b00110),
    .DIV_ALUOP(5'b00111)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                     input logic [4:0] aop);
    return {opc, rd, 15'h1234, aop, 2'b01};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an instruction for one edge, then scramble the operand inputs.
  task automatic start_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    bus.dx_insn  = insn;
    bus.dx_opA   = a;
    bus.dx_opB   = b;
    bus.dx_valid = 1'b1;
    @(posedge clock); #1;
    bus.dx_valid = 1'b0;
    bus.dx_opA   = $urandom;
    bus.dx_opB   = $urandom;
  endtask

  // Returns cycle index (1 = cycle right after start edge) when valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.md_result_valid && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic exc,
                        input int lat);
    int n;
    bus.wb_ready = 1'b1;
    start_op(insn, a, b);
    check({tag, " busy@T+1"}, bus.mult_ongoing, 1);
    check({tag, " result cleared"}, bus.md_result, (lat == 1) ? res : 32'd0);
    check({tag, " exc cleared"}, bus.md_exception, (lat == 1) ? exc : 1'b0);
    wait_valid(n);
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, bus.md_result, res);
    check({tag, " exception"}, bus.md_exception, exc);
    check({tag, " rd"}, bus.md_rd, insn[26:22]);
    check({tag, " insn"}, bus.md_insn, insn);
    @(posedge clock); #1;
    check({tag, " idle after accept"}, bus.mult_ongoing, 0);
    check({tag, " valid drop"}, bus.md_result_valid, 0);
  endtask

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  initial begin
    int n;
    logic [31:0] hold_insn;
    n_assert = 0;
    n_fail   = 0;
    reset_n      = 1'b0;
    bus.dx_insn  = '0;
    bus.dx_valid = 1'b0;
    bus.dx_opA   = '0;
    bus.dx_opB   = '0;
    bus.wb_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst busy", bus.mult_ongoing, 0);
    check("rst valid", bus.md_result_valid, 0);
    check("rst insn", bus.md_insn, 0);
    check("rst result", bus.md_result, 0);
    check("rst exc", bus.md_exception, 0);
    check("rst rd", bus.md_rd, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Non-zero opcode with a mul ALU op must not start the unit
    start_op(mk(5'd5, 5'd1, OP_MUL), 32'd6, 32'd7);
    check("non-md ignored", bus.mult_ongoing, 0);

    run_op("mul 6*7",   mk(5'd0, 5'd5, OP_MUL), 32'd6,          32'd7,          32'd42,         1'b0, 34);
    run_op("div -7/2",  mk(5'd0, 5'd3, OP_DIV), 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34);
    run_op("div 7/-2",  mk(5'd0, 5'd4, OP_DIV), 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 34);
    run_op("div by 0",  mk(5'd0, 5'd6, OP_DIV), 32'd1234,       32'd0,          32'd0,          1'b1, 1);
    run_op("mul ovf",   mk(5'd0, 5'd8, OP_MUL), 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 34);
    run_op("div ovf",   mk(5'd0, 5'd9, OP_DIV), 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 34);
    run_op("div 100/7", mk(5'd0, 5'd10, OP_DIV), 32'd100,       32'd7,          32'd14,         1'b0, 34);

    // Writeback back-pressure: result held, second start ignored
    hold_insn    = mk(5'd0, 5'd11, OP_MUL);
    bus.wb_ready = 1'b0;
    start_op(hold_insn, 32'hFFFF_FFFD, 32'd5);
    wait_valid(n);
    check("hold latency", n, 34);
    for (int i = 0; i < 10; i++) begin
      check("hold valid", bus.md_result_valid, 1);
      check("hold result", bus.md_result, 32'hFFFF_FFF1);
      check("hold exc", bus.md_exception, 0);
      check("hold insn", bus.md_insn, hold_insn);
      if (i == 3) begin
        bus.dx_insn  = mk(5'd0, 5'd12, OP_MUL);
        bus.dx_opA   = 32'd2;
        bus.dx_opB   = 32'd2;
        bus.dx_valid = 1'b1;
      end else begin
        bus.dx_valid = 1'b0;
      end
      @(posedge clock); #1;
    end
    bus.dx_valid = 1'b0;
    check("hold still busy", bus.mult_ongoing, 1);
    bus.wb_ready = 1'b1;
    @(posedge clock); #1;
    check("hold release idle", bus.mult_ongoing, 0);
    check("hold release valid", bus.md_result_valid, 0);
    check("insn kept in idle", bus.md_insn, hold_insn);

    // Asynchronous reset mid-multiply
    start_op(mk(5'd0, 5'd13, OP_MUL), 32'h1234, 32'h5678);
    repeat (9) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort busy", bus.mult_ongoing, 0);
    check("abort insn", bus.md_insn, 0);
    check("abort rd", bus.md_rd, 0);
    check("abort valid", bus.md_result_valid, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    run_op("mul 3*-4", mk(5'd0, 5'd7, OP_MUL), 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
